// File: rtl/mips_pkg.sv
// Shared load-size encodings, register constants and the misaligned-access
// predicate used by the MEM/WB stage.
package mips_pkg;

    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;
    localparam logic [4:0] REG_ZERO  = 5'd0;

    // Size 2'b11 behaves as a word access.
    function automatic logic misaligned_access(input logic [1:0] size, input logic [1:0] addr);
        logic mis;
        case (size)
            LOAD_BYTE: mis = 1'b0;
            LOAD_HALF: mis = addr[0];
            default:   mis = (addr != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational little-endian load lane selection with sign/zero extension.
// Defined for a 32-bit datapath only.
module load_formatter
    import mips_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] fmt_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        byte_ext_s;
    logic        half_ext_s;

    // Byte lane picked by the low two address bits.
    always_comb begin
        byte_s = 8'h00;
        case (addr_i)
            2'b00:   byte_s = raw_i[7:0];
            2'b01:   byte_s = raw_i[15:8];
            2'b10:   byte_s = raw_i[23:16];
            default: byte_s = raw_i[31:24];
        endcase
    end

    assign half_s     = addr_i[1] ? raw_i[31:16] : raw_i[15:0];
    assign byte_ext_s = ~unsigned_i & byte_s[7];
    assign half_ext_s = ~unsigned_i & half_s[15];

    // Final width extension according to access size.
    always_comb begin
        fmt_o = raw_i;
        case (size_i)
            LOAD_BYTE: fmt_o = {{24{byte_ext_s}}, byte_s};
            LOAD_HALF: fmt_o = {{16{half_ext_s}}, half_s};
            default:   fmt_o = raw_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load formatting, write-back select, sticky halt and
// retired counter. Optional misaligned-load trap under MEM_WB_MISALIGN_TRAP_EN.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic                      i_valid,
    input  logic [DATA_WIDTH-1:0]     i_dataread,
    input  logic [DATA_WIDTH-1:0]     i_aluresult,
    input  logic [1:0]                i_load_size,
    input  logic                      i_load_unsigned,
    input  logic                      i_memtoreg,
    input  logic                      i_regwrite,
    input  logic [REG_ADDR_WIDTH-1:0] i_rd,
    input  logic                      i_halt,
    output logic [DATA_WIDTH-1:0]     o_wbdata,
    output logic [REG_ADDR_WIDTH-1:0] o_rd,
    output logic                      o_regwrite,
    output logic                      o_valid,
    output logic                      o_halted,
    output logic [CNT_WIDTH-1:0]      o_retired,
    output logic                      o_misaligned
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]                addr_s;
    logic [31:0]               fmt_s;
    logic                      retire_s;
    logic                      misaligned_s;

    logic [DATA_WIDTH-1:0]     wbdata_q,     wbdata_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,         rd_d;
    logic                      regwrite_q,   regwrite_d;
    logic                      valid_q,      valid_d;
    logic                      halted_q,     halted_d;
    logic [CNT_WIDTH-1:0]      retired_q,    retired_d;
    logic                      misaligned_q, misaligned_d;

    assign addr_s = i_aluresult[1:0];

    load_formatter u_load_formatter (
        .raw_i      (i_dataread[31:0]),
        .addr_i     (addr_s),
        .size_i     (i_load_size),
        .unsigned_i (i_load_unsigned),
        .fmt_o      (fmt_s)
    );

    // Once halted, every later slot is converted into a bubble.
    assign retire_s = i_valid & ~halted_q;

`ifdef MEM_WB_MISALIGN_TRAP_EN
    assign misaligned_s = i_valid & i_memtoreg & misaligned_access(i_load_size, addr_s);
`else
    assign misaligned_s = 1'b0;
`endif

    // Next-state selection: flush beats stall beats capture.
    always_comb begin
        wbdata_d     = wbdata_q;
        rd_d         = rd_q;
        regwrite_d   = regwrite_q;
        valid_d      = valid_q;
        halted_d     = halted_q;
        retired_d    = retired_q;
        misaligned_d = misaligned_q;
        if (i_flush) begin
            wbdata_d     = {DATA_WIDTH{1'b0}};
            rd_d         = {REG_ADDR_WIDTH{1'b0}};
            regwrite_d   = 1'b0;
            valid_d      = 1'b0;
            misaligned_d = 1'b0;
        end else if (i_stall) begin
            valid_d      = valid_q;
        end else begin
            valid_d      = retire_s;
            regwrite_d   = retire_s & i_regwrite & (i_rd != REG_ADDR_WIDTH'(REG_ZERO)) & ~misaligned_s;
            rd_d         = i_rd;
            wbdata_d     = i_memtoreg ? DATA_WIDTH'(fmt_s) : i_aluresult;
            misaligned_d = misaligned_s;
            halted_d     = halted_q | (i_valid & i_halt);
            retired_d    = retire_s ? (retired_q + CNT_ONE) : retired_q;
        end
    end

    // Stage state registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wbdata_q     <= {DATA_WIDTH{1'b0}};
            rd_q         <= {REG_ADDR_WIDTH{1'b0}};
            regwrite_q   <= 1'b0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            retired_q    <= {CNT_WIDTH{1'b0}};
            misaligned_q <= 1'b0;
        end else begin
            wbdata_q     <= wbdata_d;
            rd_q         <= rd_d;
            regwrite_q   <= regwrite_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
            retired_q    <= retired_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_wbdata     = wbdata_q;
    assign o_rd         = rd_q;
    assign o_regwrite   = regwrite_q;
    assign o_valid      = valid_q;
    assign o_halted     = halted_q;
    assign o_retired    = retired_q;
    assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage with a behavioural write-back model checked
// after every clock edge plus hand-computed literal expectations.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        t_stall, t_flush, t_valid, t_uns, t_memtoreg, t_regwrite, t_halt;
    logic [31:0] t_raw, t_alu;
    logic [1:0]  t_size;
    logic [4:0]  t_rd;

    logic [31:0] o_wbdata;
    logic [4:0]  o_rd;
    logic        o_regwrite, o_valid, o_halted, o_misaligned;
    logic [31:0] o_retired;

    logic [31:0] m_wb;
    logic [4:0]  m_rd;
    logic        m_regwrite, m_valid, m_halted, m_mis;
    logic [31:0] m_retired;

    int n_vec  = 0;
    int n_fail = 0;

    mem_wb_stage dut (
        .i_clock         (clk),
        .i_reset         (rst_n),
        .i_stall         (t_stall),
        .i_flush         (t_flush),
        .i_valid         (t_valid),
        .i_dataread      (t_raw),
        .i_aluresult     (t_alu),
        .i_load_size     (t_size),
        .i_load_unsigned (t_uns),
        .i_memtoreg      (t_memtoreg),
        .i_regwrite      (t_regwrite),
        .i_rd            (t_rd),
        .i_halt          (t_halt),
        .o_wbdata        (o_wbdata),
        .o_rd            (o_rd),
        .o_regwrite      (o_regwrite),
        .o_valid         (o_valid),
        .o_halted        (o_halted),
        .o_retired       (o_retired),
        .o_misaligned    (o_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference load formatting via shifts and masks.
    function automatic logic [31:0] model_fmt(input logic [31:0] raw, input int a,
                                              input int size, input logic uns);
        logic [31:0] v;
        if (size == 0) begin
            v = (raw >> (8 * a)) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = (raw >> ((a >= 2) ? 16 : 0)) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    task automatic m_reset();
        m_wb = 32'h0; m_rd = 5'd0; m_regwrite = 1'b0; m_valid = 1'b0;
        m_halted = 1'b0; m_mis = 1'b0; m_retired = 32'h0;
    endtask

    task automatic model_step();
        int  a;
        logic live, mis;
        a = int'(t_alu % 32'd4);
        if (t_flush) begin
            m_valid = 1'b0; m_regwrite = 1'b0; m_mis = 1'b0; m_wb = 32'h0; m_rd = 5'd0;
        end else if (!t_stall) begin
            live = t_valid && !m_halted;
`ifdef MEM_WB_MISALIGN_TRAP_EN
            mis = t_valid && t_memtoreg &&
                  ((t_size == 2'd1 && (a % 2) == 1) || (t_size >= 2'd2 && a != 0));
`else
            mis = 1'b0;
`endif
            m_valid    = live;
            m_regwrite = live && t_regwrite && (t_rd != 5'd0) && !mis;
            m_rd       = t_rd;
            m_wb       = t_memtoreg ? model_fmt(t_raw, a, int'(t_size), t_uns) : t_alu;
            m_mis      = mis;
            if (live) m_retired = m_retired + 32'd1;
            if (t_valid && t_halt) m_halted = 1'b1;
        end
    endtask

    task automatic compare_all();
        chk("wbdata",     o_wbdata,            m_wb);
        chk("rd",         32'(o_rd),           32'(m_rd));
        chk("regwrite",   32'(o_regwrite),     32'(m_regwrite));
        chk("valid",      32'(o_valid),        32'(m_valid));
        chk("halted",     32'(o_halted),       32'(m_halted));
        chk("retired",    o_retired,           m_retired);
        chk("misaligned", 32'(o_misaligned),   32'(m_mis));
    endtask

    // One clock: model follows the edge, then outputs are compared off-edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_slot(input logic v, input logic rw, input logic [4:0] rd,
                            input logic m2r, input logic [1:0] sz, input logic uns,
                            input logic [31:0] alu, input logic [31:0] raw, input logic h);
        t_valid = v; t_regwrite = rw; t_rd = rd; t_memtoreg = m2r; t_size = sz;
        t_uns = uns; t_alu = alu; t_raw = raw; t_halt = h;
    endtask

    initial begin
        rst_n = 1'b0; t_stall = 1'b0; t_flush = 1'b0;
        set_slot(1'b0, 1'b0, 5'd0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 1'b0);
        m_reset();
        #12;
        compare_all();
        chk("reset_retired", o_retired, 32'h0);
        rst_n = 1'b1;

        for (int i = 1; i <= 5; i++) begin
            set_slot(1'b1, 1'b1, 5'(i), 1'b0, 2'b10, 1'b0, 32'h100 + 32'(i), 32'h0, 1'b0);
            tick();
        end
        chk("five_retired", o_retired, 32'd5);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        compare_all();
        chk("midreset_retired", o_retired, 32'd0);
        chk("midreset_valid", 32'(o_valid), 32'd0);
        rst_n = 1'b1;

        set_slot(1'b1, 1'b1, 5'd7, 1'b1, 2'b00, 1'b0, 32'h1000_0003, 32'h80FF_7F01, 1'b0);
        tick();
        chk("byte_s_wb", o_wbdata, 32'hFFFF_FF80);
        chk("byte_s_rd", 32'(o_rd), 32'd7);
        chk("byte_s_we", 32'(o_regwrite), 32'd1);
        t_uns = 1'b1;
        tick();
        chk("byte_u_wb", o_wbdata, 32'h0000_0080);

        set_slot(1'b1, 1'b1, 5'd8, 1'b1, 2'b01, 1'b0, 32'h1000_0002, 32'h8001_1234, 1'b0);
        tick();
        chk("half_hi_wb", o_wbdata, 32'hFFFF_8001);
        t_alu = 32'h1000_0000;
        tick();
        chk("half_lo_wb", o_wbdata, 32'h0000_1234);

        set_slot(1'b1, 1'b1, 5'd0, 1'b0, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h1111_2222, 1'b0);
        tick();
        chk("alu_wb", o_wbdata, 32'hDEAD_BEEF);
        chk("r0_we", 32'(o_regwrite), 32'd0);
        chk("alu_valid", 32'(o_valid), 32'd1);
        chk("alu_retired", o_retired, 32'd5);

        set_slot(1'b1, 1'b1, 5'd9, 1'b1, 2'b10, 1'b0, 32'h2000_0001, 32'hCAFE_F00D, 1'b0);
        tick();
`ifdef MEM_WB_MISALIGN_TRAP_EN
        chk("mis_flag", 32'(o_misaligned), 32'd1);
        chk("mis_we", 32'(o_regwrite), 32'd0);
`else
        chk("mis_flag", 32'(o_misaligned), 32'd0);
        chk("mis_we", 32'(o_regwrite), 32'd1);
`endif
        chk("mis_retired", o_retired, 32'd6);

        set_slot(1'b1, 1'b1, 5'd10, 1'b1, 2'b11, 1'b1, 32'h2000_0000, 32'h8765_4321, 1'b0);
        tick();
        chk("size11_wb", o_wbdata, 32'h8765_4321);
        chk("size11_mis", 32'(o_misaligned), 32'd0);

        t_stall = 1'b1;
        set_slot(1'b1, 1'b1, 5'd3, 1'b0, 2'b10, 1'b0, 32'h5555_AAAA, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk("stall_wb", o_wbdata, 32'h8765_4321);
        chk("stall_retired", o_retired, 32'd7);

        t_flush = 1'b1;
        t_halt = 1'b1;
        tick();
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_we", 32'(o_regwrite), 32'd0);
        chk("flush_halt", 32'(o_halted), 32'd0);
        chk("flush_retired", o_retired, 32'd7);
        t_flush = 1'b0; t_stall = 1'b0;

        set_slot(1'b1, 1'b0, 5'd0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("halt_flag", 32'(o_halted), 32'd1);
        chk("halt_valid", 32'(o_valid), 32'd1);
        chk("halt_retired", o_retired, 32'd8);
        for (int i = 0; i < 4; i++) begin
            set_slot(1'b1, 1'b1, 5'(i + 12), 1'b0, 2'b10, 1'b0, 32'h40 + 32'(i), 32'h0, 1'b0);
            tick();
        end
        chk("post_halt_valid", 32'(o_valid), 32'd0);
        chk("post_halt_we", 32'(o_regwrite), 32'd0);
        chk("post_halt_retired", o_retired, 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
